neuron_slot_scheduler: RTL and testbench

NEURON_SLOT_SCHEDULER -- requirements
Module: neuron_slot_scheduler

---
 rtl/neuron_slot_scheduler.sv | 163 ++++++++++++++++
 tb/tb_neuron_slot_scheduler.sv | 204 ++++++++++++++++++++
 2 files changed

// File: rtl/neuron_slot_scheduler.sv
// Neuron slot scheduler: paces update slots for a time-multiplexed neuron
// datapath, walks neuron indices 0..last_idx per frame, and reports frame
// boundaries, a sync point, completed frames and lost slot ticks.
module neuron_slot_scheduler #(
  parameter int unsigned NW = 9
) (
  input  logic          rawclk,
  input  logic          reset_n,
  input  logic          enable,
  input  logic [31:0]   half_cnt,
  input  logic [NW-1:0] last_idx,
  input  logic [NW-1:0] sync_idx,
  input  logic          upd_ready,
  output logic          upd_valid,
  output logic [NW-1:0] upd_idx,
  output logic          frame_start,
  output logic          sync_pulse,
  output logic [31:0]   frame_cnt,
  output logic          overrun,
  output logic [1:0]    state
);

  localparam logic [1:0] StIdle  = 2'd0;
  localparam logic [1:0] StWait  = 2'd1;
  localparam logic [1:0] StIssue = 2'd2;
  localparam logic [1:0] StDrain = 2'd3;

  logic [1:0]    r_state;
  logic [31:0]   r_pace_cnt;
  logic          r_pend;
  logic [NW-1:0] r_idx;
  logic [NW-1:0] r_last;
  logic          r_frame_start;
  logic          r_sync_pulse;
  logic [31:0]   r_frame_cnt;
  logic          r_overrun;

  logic [1:0]    w_state_nxt;
  logic [NW-1:0] w_idx_nxt;
  logic [31:0]   w_pace_nxt;
  logic          w_pend_nxt;
  logic          w_run;
  logic          w_tick;
  logic          w_valid;
  logic          w_hs;
  logic [NW-1:0] w_eff_last;
  logic          w_at_first;
  logic          w_at_last;
  logic          w_enter_issue;

  // ISSUE and DRAIN both present an update, so valid is just state bit 1.
  assign w_valid    = r_state[1];
  assign w_hs       = w_valid & upd_ready;
  assign w_run      = enable & (r_state != StIdle);
  // >= so a half_cnt lowered below the running count fires at the next compare.
  assign w_tick     = w_run & (r_pace_cnt >= half_cnt);
  assign w_at_first = (r_idx == '0);
  // At index 0 the frame length is being captured now, so use the live input.
  assign w_eff_last = w_at_first ? last_idx : r_last;
  assign w_at_last  = (r_idx == w_eff_last);

  // Pacing counter: held at 0 in IDLE, frozen while enable is low.
  always_comb begin
    w_pace_nxt = r_pace_cnt;
    if (r_state == StIdle) begin
      w_pace_nxt = '0;
    end else if (enable) begin
      w_pace_nxt = w_tick ? 32'd0 : r_pace_cnt + 32'd1;
    end
  end

  // FSM next state and index sequencing.
  always_comb begin
    w_state_nxt = r_state;
    w_idx_nxt   = r_idx;
    case (r_state)
      StIdle: begin
        w_idx_nxt = '0;
        if (enable) w_state_nxt = StWait;
      end
      StWait: begin
        if (!enable) begin
          w_state_nxt = StIdle;
          w_idx_nxt   = '0;
        end else if (w_tick || r_pend) begin
          w_state_nxt = StIssue;
        end
      end
      StIssue: begin
        if (w_hs) begin
          if (enable) begin
            w_idx_nxt   = w_at_last ? '0 : r_idx + 1'b1;
            w_state_nxt = r_pend ? StIssue : StWait;
          end else begin
            w_idx_nxt   = '0;
            w_state_nxt = StIdle;
          end
        end else if (!enable) begin
          w_state_nxt = StDrain;
        end
      end
      default: begin
        if (w_hs) begin
          w_idx_nxt   = '0;
          w_state_nxt = StIdle;
        end
      end
    endcase
  end

  // Pending slot: one tick remembered at most; consumed when ISSUE is entered.
  always_comb begin
    w_enter_issue = (w_state_nxt == StIssue) && ((r_state != StIssue) || w_hs);
    w_pend_nxt    = r_pend;
    if (w_enter_issue || (w_state_nxt == StIdle)) begin
      w_pend_nxt = 1'b0;
    end else if (w_tick) begin
      w_pend_nxt = 1'b1;
    end
  end

  // Control state registers.
  always_ff @(posedge rawclk or negedge reset_n) begin
    if (!reset_n) begin
      r_state    <= StIdle;
      r_pace_cnt <= '0;
      r_pend     <= 1'b0;
      r_idx      <= '0;
      r_overrun  <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_pace_cnt <= w_pace_nxt;
      r_pend     <= w_pend_nxt;
      r_idx      <= w_idx_nxt;
      // A tick with a slot already pending or still being issued is lost.
      r_overrun  <= r_overrun | (w_tick & (r_pend | (r_state == StIssue)));
    end
  end

  // Frame bookkeeping, all registered one cycle after the accepting handshake.
  always_ff @(posedge rawclk or negedge reset_n) begin
    if (!reset_n) begin
      r_last        <= '0;
      r_frame_start <= 1'b0;
      r_sync_pulse  <= 1'b0;
      r_frame_cnt   <= '0;
    end else begin
      r_frame_start <= w_hs & w_at_first;
      r_sync_pulse  <= w_hs & (r_idx == sync_idx);
      if (w_hs && w_at_first) r_last <= last_idx;
      if (w_hs && w_at_last) r_frame_cnt <= r_frame_cnt + 32'd1;
    end
  end

  assign upd_valid   = w_valid;
  assign upd_idx     = r_idx;
  assign frame_start = r_frame_start;
  assign sync_pulse  = r_sync_pulse;
  assign frame_cnt   = r_frame_cnt;
  assign overrun     = r_overrun;
  assign state       = r_state;

endmodule

// File: tb/tb_neuron_slot_scheduler.sv
// Directed bench for neuron_slot_scheduler: pacing, stalls/overrun, drain,
// mid-frame length change and asynchronous reset.
module tb_neuron_slot_scheduler;

  localparam int unsigned NW = 9;

  logic          rawclk;
  logic          reset_n;
  logic          enable;
  logic [31:0]   half_cnt;
  logic [NW-1:0] last_idx;
  logic [NW-1:0] sync_idx;
  logic          upd_ready;
  logic          upd_valid;
  logic [NW-1:0] upd_idx;
  logic          frame_start;
  logic          sync_pulse;
  logic [31:0]   frame_cnt;
  logic          overrun;
  logic [1:0]    state;

  int n_total;
  int n_bad;

  neuron_slot_scheduler #(.NW(NW)) dut (
    .rawclk     (rawclk),
    .reset_n    (reset_n),
    .enable     (enable),
    .half_cnt   (half_cnt),
    .last_idx   (last_idx),
    .sync_idx   (sync_idx),
    .upd_ready  (upd_ready),
    .upd_valid  (upd_valid),
    .upd_idx    (upd_idx),
    .frame_start(frame_start),
    .sync_pulse (sync_pulse),
    .frame_cnt  (frame_cnt),
    .overrun    (overrun),
    .state      (state)
  );

  initial rawclk = 1'b0;
  always #5 rawclk = ~rawclk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Advance one edge and sample 1 ns after it.
  task automatic step();
    @(posedge rawclk);
    #1;
  endtask

  // Reset, apply configuration, release just after an edge.
  task automatic restart(input logic [31:0] hc, input int li, input int si, input logic rdy);
    reset_n   = 1'b0;
    enable    = 1'b0;
    step();
    half_cnt  = hc;
    last_idx  = NW'(li);
    sync_idx  = NW'(si);
    upd_ready = rdy;
    enable    = 1'b1;
    step();
    reset_n   = 1'b1;
  endtask

  task automatic wait_valid(input int budget, output int n);
    n = 0;
    while (!upd_valid && n < budget) begin
      step();
      n++;
    end
    if (!upd_valid) check_eq("wait_valid_timeout", 32'd0, 32'd1);
  endtask

  initial begin
    int n;
    int exp_idx[8];
    logic ev;
    n_total   = 0;
    n_bad     = 0;
    reset_n   = 1'b0;
    enable    = 1'b0;
    half_cnt  = 32'd3;
    last_idx  = NW'(3);
    sync_idx  = NW'(2);
    upd_ready = 1'b1;
    step();
    step();
    check_eq("rst_state", 32'(state), 32'd0);
    check_eq("rst_valid", 32'(upd_valid), 32'd0);
    check_eq("rst_idx", 32'(upd_idx), 32'd0);
    check_eq("rst_fcnt", frame_cnt, 32'd0);
    check_eq("rst_ovr", 32'(overrun), 32'd0);

    // Steady pacing: one slot every 4 cycles, first valid 5 edges after release.
    restart(32'd3, 3, 2, 1'b1);
    for (int k = 1; k <= 22; k++) begin
      step();
      ev = (k >= 5) && ((k - 5) % 4 == 0);
      check_eq($sformatf("pace_valid_k%0d", k), 32'(upd_valid), 32'(ev));
      check_eq($sformatf("pace_state_k%0d", k), 32'(state), ev ? 32'd2 : 32'd1);
      if (ev) check_eq($sformatf("pace_idx_k%0d", k), 32'(upd_idx), 32'(((k - 5) / 4) % 4));
      check_eq($sformatf("pace_fs_k%0d", k), 32'(frame_start), 32'(k == 6 || k == 22));
      check_eq($sformatf("pace_sp_k%0d", k), 32'(sync_pulse), 32'(k == 14));
      check_eq($sformatf("pace_fc_k%0d", k), frame_cnt, (k >= 18) ? 32'd1 : 32'd0);
    end
    check_eq("pace_ovr", 32'(overrun), 32'd0);

    // Stall: ready low for 6 cycles while ticks keep arriving.
    restart(32'd1, 3, 2, 1'b0);
    step();
    step();
    for (int i = 0; i < 6; i++) begin
      step();
      check_eq($sformatf("stall_valid_%0d", i), 32'(upd_valid), 32'd1);
      check_eq($sformatf("stall_idx_%0d", i), 32'(upd_idx), 32'd0);
    end
    check_eq("stall_ovr", 32'(overrun), 32'd1);
    upd_ready = 1'b1;
    step();
    check_eq("pend_issue_state", 32'(state), 32'd2);
    check_eq("pend_issue_idx", 32'(upd_idx), 32'd1);
    step();
    check_eq("no_queue_state", 32'(state), 32'd1);
    check_eq("no_queue_idx", 32'(upd_idx), 32'd2);
    step();
    check_eq("next_tick_state", 32'(state), 32'd2);

    // Drain: enable dropped while idx 1 is stalled.
    restart(32'd3, 3, 2, 1'b1);
    for (int i = 0; i < 5; i++) step();
    check_eq("drain_first_idx", 32'(upd_idx), 32'd0);
    step();
    upd_ready = 1'b0;
    step();
    step();
    step();
    check_eq("drain_pre_state", 32'(state), 32'd2);
    check_eq("drain_pre_idx", 32'(upd_idx), 32'd1);
    enable = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step();
      check_eq($sformatf("drain_state_%0d", i), 32'(state), 32'd3);
      check_eq($sformatf("drain_valid_%0d", i), 32'(upd_valid), 32'd1);
      check_eq($sformatf("drain_idx_%0d", i), 32'(upd_idx), 32'd1);
    end
    upd_ready = 1'b1;
    step();
    check_eq("drain_end_state", 32'(state), 32'd0);
    check_eq("drain_end_valid", 32'(upd_valid), 32'd0);
    check_eq("drain_end_idx", 32'(upd_idx), 32'd0);

    // Frame length 4 -> 2 changed mid-frame; sync_idx 3 unreachable afterwards.
    restart(32'd1, 3, 3, 1'b1);
    exp_idx = '{0, 1, 2, 3, 0, 1, 0, 1};
    for (int j = 0; j < 8; j++) begin
      wait_valid(8, n);
      check_eq($sformatf("len_idx_%0d", j), 32'(upd_idx), 32'(exp_idx[j]));
      if (j == 2) last_idx = NW'(1);
      step();
      check_eq($sformatf("len_fs_%0d", j), 32'(frame_start), 32'(exp_idx[j] == 0));
      check_eq($sformatf("len_sp_%0d", j), 32'(sync_pulse), 32'(exp_idx[j] == 3));
      check_eq($sformatf("len_fc_%0d", j), frame_cnt,
               (j >= 7) ? 32'd3 : (j >= 5) ? 32'd2 : (j >= 3) ? 32'd1 : 32'd0);
    end

    // Asynchronous reset with frame_cnt=5 and overrun set.
    restart(32'd0, 3, 2, 1'b1);
    for (int i = 0; i < 100; i++) begin
      if (frame_cnt == 32'd5) break;
      step();
    end
    check_eq("pre_rst_fc", frame_cnt, 32'd5);
    step();
    check_eq("pre_rst_ovr", 32'(overrun), 32'd1);
    reset_n = 1'b0;
    #1;
    check_eq("arst_state", 32'(state), 32'd0);
    check_eq("arst_valid", 32'(upd_valid), 32'd0);
    check_eq("arst_idx", 32'(upd_idx), 32'd0);
    check_eq("arst_fs", 32'(frame_start), 32'd0);
    check_eq("arst_sp", 32'(sync_pulse), 32'd0);
    check_eq("arst_fc", frame_cnt, 32'd0);
    check_eq("arst_ovr", 32'(overrun), 32'd0);
    half_cnt = 32'd3;
    step();
    check_eq("arst_hold_state", 32'(state), 32'd0);
    reset_n = 1'b1;
    wait_valid(10, n);
    check_eq("arst_restart_lat", 32'(n), 32'd5);
    check_eq("arst_restart_idx", 32'(upd_idx), 32'd0);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
